// File: rtl/control.sv
// Multicycle LC-3b control unit: a Moore FSM that sequences fetch, decode and
// execute for ADD/AND/NOT/LDR/STR/BR. Unrecognised opcodes are treated as NOPs.
package lc3b_types;
    typedef enum logic [1:0] {alu_add, alu_and, alu_not, alu_pass} lc3b_aluop;
endpackage

module control
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic       alumux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic       regfilemux_sel,
    output logic       load_pc,
    output logic       load_cc,
    output logic       load_ir,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_regfile,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable
);

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT,
        CALC_ADDR, LDR1, LDR2, STR1, STR2, BR, BR_TAKEN
    } state_t;

    state_t state_q, state_d;

    assign mem_byte_enable = 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH1;
        else        state_q <= state_d;
    end

    // Outputs are forced to defaults while reset is held so a pending memory
    // request is withdrawn immediately, not at the next edge.
    always_comb begin
        state_d        = state_q;
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = 1'b0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        load_pc        = 1'b0;
        load_cc        = 1'b0;
        load_ir        = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_regfile   = 1'b0;
        aluop          = alu_add;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                    state_d    = FETCH2;
                end
                FETCH2: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = mem_resp;
                    if (mem_resp) state_d = FETCH3;
                end
                FETCH3: begin
                    load_ir = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    unique case (opcode)
                        4'b0001:          state_d = S_ADD;
                        4'b0101:          state_d = S_AND;
                        4'b1001:          state_d = S_NOT;
                        4'b0110, 4'b0111: state_d = CALC_ADDR;
                        4'b0000:          state_d = BR;
                        default:          state_d = FETCH1;
                    endcase
                end
                S_ADD, S_AND: begin
                    aluop        = (state_q == S_AND) ? alu_and : alu_add;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    state_d      = FETCH1;
                end
                S_NOT: begin
                    aluop        = alu_not;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    state_d      = FETCH1;
                end
                CALC_ADDR: begin
                    alumux_sel = 1'b1;
                    load_mar   = 1'b1;
                    state_d    = (opcode == 4'b0110) ? LDR1 : STR1;
                end
                LDR1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = mem_resp;
                    if (mem_resp) state_d = LDR2;
                end
                LDR2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    state_d        = FETCH1;
                end
                STR1: begin
                    storemux_sel = 1'b1;
                    aluop        = alu_pass;
                    load_mdr     = 1'b1;
                    state_d      = STR2;
                end
                STR2: begin
                    mem_write = 1'b1;
                    if (mem_resp) state_d = FETCH1;
                end
                BR: begin
                    state_d = branch_enable ? BR_TAKEN : FETCH1;
                end
                BR_TAKEN: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                    state_d   = FETCH1;
                end
                default: state_d = FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_control.sv
// Bench for control: instruction-level expected traces (table-driven and random)
// compared cycle by cycle against the DUT, plus a reset-during-wait sequence.
module tb_control;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       branch_enable = 1'b0;
    logic       mem_resp = 1'b0;
    logic       pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, regfilemux_sel;
    logic       load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile;
    lc3b_aluop  aluop;
    logic       mem_read, mem_write;
    logic [1:0] mem_byte_enable;

    control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_enable(branch_enable),
        .mem_resp(mem_resp), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
        .alumux_sel(alumux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
        .regfilemux_sel(regfilemux_sel), .load_pc(load_pc), .load_cc(load_cc),
        .load_ir(load_ir), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_regfile(load_regfile), .aluop(aluop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcmux, storemux, alumux, marmux, mdrmux, regfilemux;
        logic ld_pc, ld_cc, ld_ir, ld_mar, ld_mdr, ld_rf, rd, wr;
        lc3b_aluop op;
        logic [1:0] be;
    } out_t;

    typedef struct {
        logic mr;
        out_t exp;
    } cyc_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       be;
        int         wf, wm;
        int         rf, pc, rd, wr;
    } vec_t;

    out_t act;
    assign act = {pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, regfilemux_sel,
                  load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile,
                  mem_read, mem_write, aluop, mem_byte_enable};

    int   checks = 0;
    int   errors = 0;
    cyc_t q[$];
    vec_t tbl[9];

    function automatic out_t dflt();
        out_t o;
        o    = '0;
        o.op = alu_add;
        o.be = 2'b11;
        return o;
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input out_t e);
        cyc_t c;
        c.mr  = mr;
        c.exp = e;
        q.push_back(c);
    endtask

    // Expected per-cycle outputs of one whole instruction, from the state-by-state
    // behaviour; mem_resp is junk outside the memory wait states.
    task automatic build(input logic [3:0] op, input logic be, input int wf, input int wm);
        out_t o;
        q.delete();
        o = dflt(); o.marmux = 1; o.ld_mar = 1; o.ld_pc = 1; push(rnd(), o);
        for (int i = 0; i <= wf; i++) begin
            o = dflt(); o.rd = 1; o.mdrmux = 1; o.ld_mdr = (i == wf); push(i == wf, o);
        end
        o = dflt(); o.ld_ir = 1; push(rnd(), o);
        o = dflt(); push(rnd(), o);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                o = dflt(); o.ld_rf = 1; o.ld_cc = 1;
                o.op = (op == 4'b0001) ? alu_add : (op == 4'b0101) ? alu_and : alu_not;
                push(rnd(), o);
            end
            4'b0110, 4'b0111: begin
                o = dflt(); o.alumux = 1; o.ld_mar = 1; push(rnd(), o);
                if (op == 4'b0110) begin
                    for (int i = 0; i <= wm; i++) begin
                        o = dflt(); o.rd = 1; o.mdrmux = 1; o.ld_mdr = (i == wm); push(i == wm, o);
                    end
                    o = dflt(); o.regfilemux = 1; o.ld_rf = 1; o.ld_cc = 1; push(rnd(), o);
                end else begin
                    o = dflt(); o.storemux = 1; o.op = alu_pass; o.ld_mdr = 1; push(rnd(), o);
                    for (int i = 0; i <= wm; i++) begin
                        o = dflt(); o.wr = 1; push(i == wm, o);
                    end
                end
            end
            4'b0000: begin
                o = dflt(); push(rnd(), o);
                if (be) begin
                    o = dflt(); o.pcmux = 1; o.ld_pc = 1; push(rnd(), o);
                end
            end
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; outputs sampled on the falling edge.
    task automatic apply(input string name, input int limit,
                         output int n_rf, output int n_pc, output int n_rd, output int n_wr);
        int n;
        n_rf = 0; n_pc = 0; n_rd = 0; n_wr = 0;
        n = (limit < 0) ? q.size() : limit;
        for (int i = 0; i < n; i++) begin
            mem_resp = q[i].mr;
            @(negedge clk);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, i, act, q[i].exp);
            end
            n_rf += int'(act.ld_rf);
            n_pc += int'(act.ld_pc);
            n_rd += int'(act.rd);
            n_wr += int'(act.wr);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic chk_out(input string name, input out_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", name, act, want);
        end
    endtask

    initial begin
        int   rf, pc, rd, wr;
        out_t f1, f2;

        tbl[0] = '{"add_wait1", 4'b0001, 1'b0, 1, 0, 1, 1, 2, 0};
        tbl[1] = '{"and",       4'b0101, 1'b0, 0, 0, 1, 1, 1, 0};
        tbl[2] = '{"not_wait2", 4'b1001, 1'b0, 2, 0, 1, 1, 3, 0};
        tbl[3] = '{"ldr_wait3", 4'b0110, 1'b0, 0, 3, 1, 1, 5, 0};
        tbl[4] = '{"str_wait2", 4'b0111, 1'b0, 0, 2, 0, 1, 1, 3};
        tbl[5] = '{"br_not",    4'b0000, 1'b0, 0, 0, 0, 1, 1, 0};
        tbl[6] = '{"br_taken",  4'b0000, 1'b1, 1, 0, 0, 2, 2, 0};
        tbl[7] = '{"nop_1111",  4'b1111, 1'b1, 0, 0, 0, 1, 1, 0};
        tbl[8] = '{"nop_0100",  4'b0100, 1'b0, 1, 0, 0, 1, 2, 0};

        f1 = dflt(); f1.marmux = 1; f1.ld_mar = 1; f1.ld_pc = 1;
        f2 = dflt(); f2.rd = 1; f2.mdrmux = 1;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("reset_defaults", dflt());
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            opcode = tbl[k].op;
            branch_enable = tbl[k].be;
            build(tbl[k].op, tbl[k].be, tbl[k].wf, tbl[k].wm);
            apply(tbl[k].name, -1, rf, pc, rd, wr);
            chk({tbl[k].name, "_load_regfile_cycles"}, rf, tbl[k].rf);
            chk({tbl[k].name, "_load_pc_cycles"}, pc, tbl[k].pc);
            chk({tbl[k].name, "_mem_read_cycles"}, rd, tbl[k].rd);
            chk({tbl[k].name, "_mem_write_cycles"}, wr, tbl[k].wr);
            $display("vector %s opcode=%b be=%b: rf=%0d pc=%0d rd=%0d wr=%0d",
                     tbl[k].name, tbl[k].op, tbl[k].be, rf, pc, rd, wr);
        end

        // Reset asserted while LDR1 is waiting on memory.
        opcode = 4'b0110;
        branch_enable = 1'b0;
        build(4'b0110, 1'b0, 0, 5);
        apply("ldr_pre_reset", 6, rf, pc, rd, wr);
        mem_resp = 1'b0;
        #1;
        chk("ldr1_mem_read_before_reset", int'(mem_read), 1);
        rst_n = 1'b0;
        #1;
        chk("mem_read_dropped_in_reset", int'(mem_read), 0);
        chk_out("reset_mid_ldr1_defaults", dflt());
        @(posedge clk); #1;
        chk_out("reset_held_defaults", dflt());
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("release_fetch1_outputs", f1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_out("release_then_fetch2", f2);
        $display("reset sequence done");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            logic       be;
            int         wf, wm;
            op = 4'($urandom_range(0, 15));
            be = rnd();
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            opcode = op;
            branch_enable = be;
            build(op, be, wf, wm);
            apply("random", -1, rf, pc, rd, wr);
            $display("random %0d opcode=%b be=%b wf=%0d wm=%0d cycles=%0d",
                     n, op, be, wf, wm, q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters: none; aluop uses the shared lc3b_aluop enumeration (alu_add, alu_and, alu_not, alu_pass).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  4  IR[15:12] from datapath.
REQ-005 branch_enable  input  1  nzp match of IR[11:9] against CC.
REQ-006 mem_resp  input  1  memory access complete, valid one cycle.
REQ-007 pcmux_sel  output  1  0 = PC+2, 1 = branch adder.
REQ-008 storemux_sel  output  1  0 = IR sr1 field, 1 = IR dest field onto regfile port A.
REQ-009 alumux_sel  output  1  0 = SR2, 1 = sext(offset6)<<1.
REQ-010 marmux_sel  output  1  0 = ALU out, 1 = PC.
REQ-011 mdrmux_sel  output  1  0 = ALU out, 1 = mem_rdata.
REQ-012 regfilemux_sel  output  1  0 = ALU out, 1 = MDR.
REQ-013 load_pc  output  1  PC write enable.
REQ-014 load_cc  output  1  CC write enable.
REQ-015 load_ir  output  1  IR write enable.
REQ-016 load_mar  output  1  MAR write enable.
REQ-017 load_mdr  output  1  MDR write enable.
REQ-018 load_regfile  output  1  regfile write enable.
REQ-019 aluop  output  lc3b_aluop  ALU operation.
REQ-020 mem_read  output  1  memory read request, level.
REQ-021 mem_write  output  1  memory write request, level.
REQ-022 mem_byte_enable  output  2  byte lanes; always 2'b11.

Function
REQ-023 Moore FSM; outputs combinational from state only, except load_mdr in wait states (also gated by mem_resp); default all 1-bit outputs 0, aluop = alu_add.
REQ-024 States: FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, CALC_ADDR, LDR1, LDR2, STR1, STR2, BR, BR_TAKEN.
REQ-025 FETCH1: marmux_sel=1, load_mar=1, pcmux_sel=0, load_pc=1 (MAR<-PC, PC<-PC+2); -> FETCH2.
REQ-026 FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=mem_resp; stay while mem_resp=0, -> FETCH3 on mem_resp=1.
REQ-027 FETCH3: load_ir=1; -> DECODE.
REQ-028 DECODE: no outputs; opcode 0001->S_ADD, 0101->S_AND, 1001->S_NOT, 0110/0111->CALC_ADDR, 0000->BR, any other -> FETCH1 (treated as NOP).
REQ-029 S_ADD/S_AND: alumux_sel=0, aluop=alu_add/alu_and, load_regfile=1, load_cc=1; -> FETCH1.
REQ-030 S_NOT: aluop=alu_not, load_regfile=1, load_cc=1; -> FETCH1.
REQ-031 CALC_ADDR: alumux_sel=1, aluop=alu_add, marmux_sel=0, load_mar=1; opcode 0110 -> LDR1, 0111 -> STR1.
REQ-032 LDR1: mem_read=1, mdrmux_sel=1, load_mdr=mem_resp; hold until mem_resp=1, then -> LDR2.
REQ-033 LDR2: regfilemux_sel=1, load_regfile=1, load_cc=1; -> FETCH1.
REQ-034 STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr=1; -> STR2.
REQ-035 STR2: mem_write=1; hold until mem_resp=1, then -> FETCH1.
REQ-036 BR: no outputs; branch_enable=1 -> BR_TAKEN, else -> FETCH1.
REQ-037 BR_TAKEN: pcmux_sel=1, load_pc=1; -> FETCH1.
REQ-038 mem_read and mem_write never asserted in the same cycle; request held stable until the cycle mem_resp=1.
REQ-039 mem_resp outside FETCH2/LDR1/STR2 is ignored.

Reset
REQ-040 rst_n=0 forces state to FETCH1 asynchronously and forces all outputs to defaults (mem_byte_enable stays 2'b11) while low, including mid-wait in FETCH2/LDR1/STR2 (request dropped immediately).
REQ-041 First rising edge with rst_n=1 executes FETCH1.

Verification
REQ-042 ADD (opcode 0001), mem_resp after 1 wait cycle -> states FETCH1,FETCH2,FETCH2,FETCH3,DECODE,S_ADD,FETCH1; load_regfile and load_cc high exactly 1 cycle.
REQ-043 LDR (0110), mem_resp delayed 3 cycles in LDR1 -> mem_read high 4 cycles, load_mdr high only on the response cycle, then LDR2 with regfilemux_sel=1.
REQ-044 STR (0111) -> STR1 storemux_sel=1, aluop=alu_pass; STR2 mem_write high until mem_resp, mem_read 0 throughout.
REQ-045 BR with branch_enable=0 -> 5-cycle instruction with no second load_pc; with branch_enable=1 -> BR_TAKEN asserts pcmux_sel=1, load_pc=1 for 1 cycle.
REQ-046 Opcode 1111 -> DECODE returns to FETCH1, no load_regfile/load_cc/mem_write asserted.
REQ-047 rst_n low mid-LDR1 with mem_read=1 -> mem_read drops same cycle; after release, FETCH1 outputs on first edge.
